// File: rtl/ls1u_dbus_bridge.sv
//------------------------------------------------------------------------------
// ls1u_dbus_bridge
//
// Bridges the LS1U CPU data port onto a simple request/acknowledge external
// bus. Loads stall the CPU until the read data has returned. Writes are
// posted: the CPU keeps running unless it issues another load or an MDR write
// while the write is still pending. A wait counter aborts any transfer that
// the slave does not acknowledge within TIMEOUT cycles.
//
// Parameters
//   TIMEOUT    bus wait cycles before a transfer is aborted (1..255)
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   cpu_op     CPU instruction funct5 (bits [15:11]), not WAIT-gated
//   cpu_dst    CPU instruction write-back destination (bits [10:8])
//   daddr      CPU data address
//   ddata_o    CPU MDR contents (write data)
//   dwrite     one-cycle CPU write strobe
//   ddata_i    read data returned to the CPU
//   WAIT       combinational CPU stall request
//   bus_req    external transfer request
//   bus_we     1 = write, 0 = read
//   bus_addr   transfer address
//   bus_wdata  write data
//   bus_rdata  read data, valid with bus_ack
//   bus_ack    slave completion, only honoured while bus_req = 1
//   bus_err    one-cycle pulse on timeout abort
//------------------------------------------------------------------------------
module ls1u_dbus_bridge #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  cpu_op,
   input  logic [2:0]  cpu_dst,
   input  logic [23:0] daddr,
   input  logic [7:0]  ddata_o,
   input  logic        dwrite,
   output logic [7:0]  ddata_i,
   output logic        WAIT,
   output logic        bus_req,
   output logic        bus_we,
   output logic [23:0] bus_addr,
   output logic [7:0]  bus_wdata,
   input  logic [7:0]  bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD      = 2'd1,
      RD_DONE = 2'd2,
      WR      = 2'd3
   } state_t;

   // The counter value seen in the last permitted wait cycle.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   state_t      next_state;
   logic [7:0]  rd_reg;
   logic [7:0]  wait_cnt;
   logic        is_load;
   logic        is_mdr_wr;
   logic        ack_valid;
   logic        timeout;

   assign is_load = (cpu_op == 5'h04);

   // Instructions that write the MDR back must not overwrite it while a
   // posted write still needs the old value on the bus.
   always_comb begin
      is_mdr_wr = 1'b0;
      if (cpu_dst == 3'h7) begin
         case (cpu_op)
            5'h02, 5'h04, 5'h05, 5'h06, 5'h07, 5'h0D, 5'h10,
            5'h12, 5'h14, 5'h16, 5'h18, 5'h1A, 5'h1C: is_mdr_wr = 1'b1;
            default:                                  is_mdr_wr = 1'b0;
         endcase
      end
   end

   // An acknowledge only counts while a request is outstanding; an ack in
   // the final wait cycle wins over the timeout.
   assign ack_valid = bus_ack & bus_req;
   assign timeout   = ~ack_valid & (wait_cnt == TIMEOUT_LAST);

   assign ddata_i = rd_reg;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: a write strobe takes priority over a load, and both
   // transfer states leave on either ack or timeout.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (dwrite) begin
               next_state = WR;
            end else if (is_load) begin
               next_state = RD;
            end
         end
         RD: begin
            if (ack_valid || timeout) begin
               next_state = RD_DONE;
            end
         end
         RD_DONE: next_state = IDLE;
         WR: begin
            if (ack_valid || timeout) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // CPU stall: a load stalls from issue until the data is back; a pending
   // write only stalls instructions that would need the bus or the MDR.
   // Reset forces the stall low since the state register is already IDLE.
   always_comb begin
      WAIT = 1'b0;
      case (state)
         IDLE:    WAIT = is_load;
         RD:      WAIT = 1'b1;
         WR:      WAIT = is_load | is_mdr_wr;
         default: WAIT = 1'b0;
      endcase
      if (rst) begin
         WAIT = 1'b0;
      end
   end

   // Bus datapath: request fields are captured when a transfer starts and
   // held unchanged until it completes; the counter runs only while waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= 24'h0;
         bus_wdata <= 8'h00;
         bus_err   <= 1'b0;
         rd_reg    <= 8'h00;
         wait_cnt  <= 8'h00;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (dwrite) begin
                  bus_addr  <= daddr;
                  bus_wdata <= ddata_o;
                  bus_we    <= 1'b1;
                  bus_req   <= 1'b1;
                  wait_cnt  <= 8'h00;
               end else if (is_load) begin
                  bus_addr <= daddr;
                  bus_we   <= 1'b0;
                  bus_req  <= 1'b1;
                  wait_cnt <= 8'h00;
               end
            end
            RD: begin
               if (ack_valid) begin
                  rd_reg  <= bus_rdata;
                  bus_req <= 1'b0;
               end else if (timeout) begin
                  rd_reg  <= 8'hFF;
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            WR: begin
               if (ack_valid) begin
                  bus_req <= 1'b0;
               end else if (timeout) begin
                  bus_req <= 1'b0;
                  bus_err <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 8'h01;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ls1u_dbus_bridge.sv
//------------------------------------------------------------------------------
// tb_ls1u_dbus_bridge
//
// Directed bench for ls1u_dbus_bridge with TIMEOUT = 4. A table of per-cycle
// vectors covers reset, load, posted write, back-to-back write/load and write
// priority; hand-written sequences cover the read timeout, the ack/timeout
// tie and an asynchronous reset in the middle of a read.
//------------------------------------------------------------------------------
module tb_ls1u_dbus_bridge;

   logic        clk;
   logic        rst;
   logic [4:0]  cpu_op;
   logic [2:0]  cpu_dst;
   logic [23:0] daddr;
   logic [7:0]  ddata_o;
   logic        dwrite;
   logic [7:0]  ddata_i;
   logic        WAIT;
   logic        bus_req;
   logic        bus_we;
   logic [23:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        bus_ack;
   logic        bus_err;

   int checks;
   int errors;

   typedef struct {
      string       name;
      logic        rst;
      logic [4:0]  op;
      logic [2:0]  dst;
      logic [23:0] daddr;
      logic [7:0]  wdata;
      logic        dwrite;
      logic [7:0]  rdata;
      logic        ack;
      logic [43:0] expect_out;
   } vec_t;

   vec_t vecs[$];

   ls1u_dbus_bridge #(.TIMEOUT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_op    (cpu_op),
      .cpu_dst   (cpu_dst),
      .daddr     (daddr),
      .ddata_o   (ddata_o),
      .dwrite    (dwrite),
      .ddata_i   (ddata_i),
      .WAIT      (WAIT),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Packs the observable outputs into one word for a single comparison.
   function automatic logic [43:0] pack_out(input logic [7:0] dd, input logic w,
                                            input logic r, input logic we,
                                            input logic [23:0] a, input logic [7:0] wd,
                                            input logic e);
      return {dd, w, r, we, a, wd, e};
   endfunction

   // Adds one cycle of stimulus together with the outputs expected in it.
   task automatic add_vec(input string n, input logic r, input logic [4:0] op,
                          input logic [2:0] dst, input logic [23:0] a,
                          input logic [7:0] wd, input logic dw, input logic [7:0] rd,
                          input logic ack, input logic [43:0] ex);
      vec_t v;
      v.name = n; v.rst = r; v.op = op; v.dst = dst; v.daddr = a;
      v.wdata = wd; v.dwrite = dw; v.rdata = rd; v.ack = ack; v.expect_out = ex;
      vecs.push_back(v);
   endtask

   task automatic applyStimulus(input vec_t v);
      rst       = v.rst;
      cpu_op    = v.op;
      cpu_dst   = v.dst;
      daddr     = v.daddr;
      ddata_o   = v.wdata;
      dwrite    = v.dwrite;
      bus_rdata = v.rdata;
      bus_ack   = v.ack;
   endtask

   task automatic checkOutput(input string n, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", n, actual, expected);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int req_cycles;
      bit seen_err;

      rst = 1'b1; cpu_op = 5'h00; cpu_dst = 3'h0; daddr = 24'h0;
      ddata_o = 8'h00; dwrite = 1'b0; bus_rdata = 8'h00; bus_ack = 1'b0;
      checks = 0;
      errors = 0;

      // Reset, then a load acked in its second bus cycle.
      add_vec("reset_hold", 1, 5'h04, 3'h0, 24'h001234, 8'h00, 0, 8'h00, 0, pack_out(8'h00, 0, 0, 0, 24'h000000, 8'h00, 0));
      add_vec("idle",       0, 5'h00, 3'h0, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'h00, 0, 0, 0, 24'h000000, 8'h00, 0));
      add_vec("ld_issue",   0, 5'h04, 3'h0, 24'h001234, 8'h00, 0, 8'h00, 0, pack_out(8'h00, 1, 0, 0, 24'h000000, 8'h00, 0));
      add_vec("ld_rd1",     0, 5'h04, 3'h0, 24'h001234, 8'h00, 0, 8'h00, 0, pack_out(8'h00, 1, 1, 0, 24'h001234, 8'h00, 0));
      add_vec("ld_rd_ack",  0, 5'h04, 3'h0, 24'h001234, 8'h00, 0, 8'hA5, 1, pack_out(8'h00, 1, 1, 0, 24'h001234, 8'h00, 0));
      add_vec("ld_done",    0, 5'h04, 3'h0, 24'h001234, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 0, 0, 0, 24'h001234, 8'h00, 0));
      add_vec("ld_idle",    0, 5'h00, 3'h0, 24'h001234, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 0, 0, 0, 24'h001234, 8'h00, 0));
      // Posted write followed by a non-MDR ALU op: no stall.
      add_vec("wr_issue",   0, 5'h00, 3'h0, 24'h00FF00, 8'h3C, 1, 8'h00, 0, pack_out(8'hA5, 0, 0, 0, 24'h001234, 8'h00, 0));
      add_vec("wr_alu",     0, 5'h01, 3'h7, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 0, 1, 1, 24'h00FF00, 8'h3C, 0));
      add_vec("wr_ack",     0, 5'h01, 3'h7, 24'h000000, 8'h00, 0, 8'h00, 1, pack_out(8'hA5, 0, 1, 1, 24'h00FF00, 8'h3C, 0));
      add_vec("wr_dropped", 0, 5'h00, 3'h0, 24'h000000, 8'h00, 0, 8'h00, 1, pack_out(8'hA5, 0, 0, 1, 24'h00FF00, 8'h3C, 0));
      add_vec("stray_ack",  0, 5'h00, 3'h0, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 0, 0, 1, 24'h00FF00, 8'h3C, 0));
      // Write pending, MDR write and load stall until ack, then the read.
      add_vec("b2b_wr",     0, 5'h00, 3'h0, 24'h000010, 8'h5A, 1, 8'h00, 0, pack_out(8'hA5, 0, 0, 1, 24'h00FF00, 8'h3C, 0));
      add_vec("b2b_mdr",    0, 5'h02, 3'h7, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 1, 1, 1, 24'h000010, 8'h5A, 0));
      add_vec("b2b_ld_w",   0, 5'h04, 3'h0, 24'h000020, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 1, 1, 1, 24'h000010, 8'h5A, 0));
      add_vec("b2b_wr_ack", 0, 5'h04, 3'h0, 24'h000020, 8'h00, 0, 8'h00, 1, pack_out(8'hA5, 1, 1, 1, 24'h000010, 8'h5A, 0));
      add_vec("b2b_gap",    0, 5'h04, 3'h0, 24'h000020, 8'h00, 0, 8'h00, 0, pack_out(8'hA5, 1, 0, 1, 24'h000010, 8'h5A, 0));
      add_vec("b2b_rd_ack", 0, 5'h04, 3'h0, 24'h000020, 8'h00, 0, 8'hC3, 1, pack_out(8'hA5, 1, 1, 0, 24'h000020, 8'h5A, 0));
      add_vec("b2b_done",   0, 5'h04, 3'h0, 24'h000020, 8'h00, 0, 8'h00, 0, pack_out(8'hC3, 0, 0, 0, 24'h000020, 8'h5A, 0));
      add_vec("b2b_idle",   0, 5'h00, 3'h0, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'hC3, 0, 0, 0, 24'h000020, 8'h5A, 0));
      // Write strobe beats a simultaneous load; a stray strobe in WR is ignored.
      add_vec("prio_issue", 0, 5'h04, 3'h0, 24'h000030, 8'h77, 1, 8'h00, 0, pack_out(8'hC3, 1, 0, 0, 24'h000020, 8'h5A, 0));
      add_vec("prio_wr",    0, 5'h04, 3'h0, 24'h000099, 8'h11, 1, 8'h00, 0, pack_out(8'hC3, 1, 1, 1, 24'h000030, 8'h77, 0));
      add_vec("prio_ack",   0, 5'h04, 3'h0, 24'h000099, 8'h11, 0, 8'h00, 1, pack_out(8'hC3, 1, 1, 1, 24'h000030, 8'h77, 0));
      add_vec("prio_idle",  0, 5'h00, 3'h0, 24'h000000, 8'h00, 0, 8'h00, 0, pack_out(8'hC3, 0, 0, 1, 24'h000030, 8'h77, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         @(negedge clk);
         checkOutput(vecs[i].name,
                     64'(pack_out(ddata_i, WAIT, bus_req, bus_we, bus_addr, bus_wdata, bus_err)),
                     64'(vecs[i].expect_out));
         next_cycle();
      end

      // Read timeout: request held for four wait cycles, then one error pulse.
      cpu_op = 5'h04; cpu_dst = 3'h0; daddr = 24'h000040; bus_ack = 1'b0; dwrite = 1'b0;
      next_cycle();
      req_cycles = 0;
      seen_err = 1'b0;
      for (int i = 0; i < 20 && !seen_err; i++) begin
         @(negedge clk);
         if (bus_err) begin
            seen_err = 1'b1;
         end else begin
            if (bus_req) req_cycles++;
            next_cycle();
         end
      end
      checkOutput("tmo_err_seen", 64'(seen_err), 64'd1);
      checkOutput("tmo_req_cycles", 64'(req_cycles), 64'd4);
      checkOutput("tmo_rd_done", 64'({ddata_i, WAIT, bus_req}), 64'({8'hFF, 1'b0, 1'b0}));
      next_cycle();
      cpu_op = 5'h00;
      @(negedge clk);
      checkOutput("tmo_err_single", 64'({bus_err, bus_req, WAIT}), 64'd0);
      next_cycle();

      // Ack in the final wait cycle wins over the timeout.
      cpu_op = 5'h04; daddr = 24'h000050;
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         next_cycle();
      end
      bus_ack = 1'b1; bus_rdata = 8'h5E;
      next_cycle();
      bus_ack = 1'b0; bus_rdata = 8'h00;
      @(negedge clk);
      checkOutput("tie_ack_wins", 64'({ddata_i, bus_err, bus_req, WAIT}), 64'({8'h5E, 1'b0, 1'b0, 1'b0}));
      next_cycle();
      cpu_op = 5'h00;
      @(negedge clk);
      checkOutput("tie_no_err", 64'({bus_err, bus_req}), 64'd0);
      next_cycle();

      // Asynchronous reset in the middle of a read.
      cpu_op = 5'h04; daddr = 24'h000060;
      next_cycle();
      @(negedge clk);
      checkOutput("rst_pre_req", 64'({bus_req, WAIT}), 64'({1'b1, 1'b1}));
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_async", 64'({bus_req, WAIT, bus_err}), 64'd0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_idle", 64'({ddata_i, WAIT, bus_req, bus_err}), 64'({8'h00, 1'b1, 1'b0, 1'b0}));
      next_cycle();
      cpu_op = 5'h00;
      next_cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
